// File: rtl/btb_pkg.sv
// ============================================================================
// Module : btb_pkg
// Desc   : Shared types, slicing helpers and counter constants for the BTB.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package btb_pkg;

    localparam int BTB_MAX_W = 32;
    localparam int CTR_MAX_W = 8;

    // Fields are sized for the widest supported PC; unused upper bits stay zero.
    typedef struct packed {
        logic                 valid;
        logic                 cond;
        logic [BTB_MAX_W-1:0] tag;
        logic [BTB_MAX_W-1:0] target;
    } btb_entry_t;

    function automatic logic [CTR_MAX_W-1:0] ctr_weak_nt(input int bits);
        return (CTR_MAX_W'(1) << (bits - 1)) - CTR_MAX_W'(1);
    endfunction

    function automatic logic [CTR_MAX_W-1:0] ctr_weak_t(input int bits);
        return CTR_MAX_W'(1) << (bits - 1);
    endfunction

    function automatic logic [BTB_MAX_W-1:0] btb_index(input logic [BTB_MAX_W-1:0] pc,
                                                       input int ib);
        return pc & ((BTB_MAX_W'(1) << ib) - BTB_MAX_W'(1));
    endfunction

    function automatic logic [BTB_MAX_W-1:0] btb_tag(input logic [BTB_MAX_W-1:0] pc,
                                                     input int ib);
        return pc >> ib;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module : sat_counter
// Desc   : Saturating direction counter; load forces weakly-taken.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sat_counter
    import btb_pkg::*;
#(
    parameter int CTR_BITS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_dec,
    input  logic i_load,
    output logic o_taken
);

    localparam logic [CTR_BITS-1:0] c_WEAK_NT = CTR_BITS'(ctr_weak_nt(CTR_BITS));
    localparam logic [CTR_BITS-1:0] c_WEAK_T  = CTR_BITS'(ctr_weak_t(CTR_BITS));
    localparam logic [CTR_BITS-1:0] c_MAX     = '1;
    localparam logic [CTR_BITS-1:0] c_ONE     = CTR_BITS'(1);

    logic [CTR_BITS-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= c_WEAK_NT;
        end else if (i_load) begin
            r_count <= c_WEAK_T;
        end else if (i_inc && (r_count != c_MAX)) begin
            r_count <= r_count + c_ONE;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - c_ONE;
        end
    end

    assign o_taken = r_count[CTR_BITS-1];

endmodule

`default_nettype wire

// File: rtl/btb_predictor.sv
// ============================================================================
// Module : btb_predictor
// Desc   : Direct-mapped BTB with saturating direction counters, optional gshare.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module btb_predictor
    import btb_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int INDEX_BITS = 4,
    parameter int CTR_BITS   = 2,
    parameter int GHR_BITS   = 0,
    parameter int STAT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] lookup_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    output logic [WORD_SIZE-1:0] pred_target,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic                 upd_cond,
    input  logic                 upd_taken,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 upd_mispredict,
    input  logic                 flush,
    output logic [STAT_BITS-1:0] stat_updates,
    output logic [STAT_BITS-1:0] stat_mispred
);

    localparam int c_ENTRIES = 1 << INDEX_BITS;

    btb_entry_t            r_entry [c_ENTRIES];
    logic [STAT_BITS-1:0]  r_stat_upd;
    logic [STAT_BITS-1:0]  r_stat_mis;
    logic [c_ENTRIES-1:0]  w_ctr_taken;
    logic [INDEX_BITS-1:0] w_ghr_ext;
    logic [INDEX_BITS-1:0] w_lk_idx;
    logic [INDEX_BITS-1:0] w_lk_cidx;
    logic [INDEX_BITS-1:0] w_up_idx;
    logic [INDEX_BITS-1:0] w_up_cidx;
    logic [BTB_MAX_W-1:0]  w_lk_tag;
    logic [BTB_MAX_W-1:0]  w_up_tag;
    logic                  w_up_hit;
    logic                  w_accept;
    logic                  w_alloc;

    assign w_lk_idx  = INDEX_BITS'(btb_index(BTB_MAX_W'(lookup_pc), INDEX_BITS));
    assign w_lk_tag  = btb_tag(BTB_MAX_W'(lookup_pc), INDEX_BITS);
    assign w_lk_cidx = w_lk_idx ^ w_ghr_ext;
    assign w_up_idx  = INDEX_BITS'(btb_index(BTB_MAX_W'(upd_pc), INDEX_BITS));
    assign w_up_tag  = btb_tag(BTB_MAX_W'(upd_pc), INDEX_BITS);
    assign w_up_cidx = w_up_idx ^ w_ghr_ext;

    assign pred_hit    = r_entry[w_lk_idx].valid && (r_entry[w_lk_idx].tag == w_lk_tag);
    assign pred_taken  = pred_hit && (!r_entry[w_lk_idx].cond || w_ctr_taken[w_lk_cidx]);
    assign pred_target = pred_taken ? WORD_SIZE'(r_entry[w_lk_idx].target)
                                    : lookup_pc + WORD_SIZE'(1);

    // Flush dominates any update presented in the same cycle.
    assign w_up_hit = r_entry[w_up_idx].valid && (r_entry[w_up_idx].tag == w_up_tag);
    assign w_accept = upd_valid && !flush;
    assign w_alloc  = w_accept && !w_up_hit && upd_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_entry[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_entry[i].valid <= 1'b0;
            end
        end else if (upd_valid && upd_taken) begin
            if (w_up_hit) begin
                r_entry[w_up_idx].target <= BTB_MAX_W'(upd_target);
            end else begin
                r_entry[w_up_idx] <= '{valid:  1'b1,
                                       cond:   upd_cond,
                                       tag:    w_up_tag,
                                       target: BTB_MAX_W'(upd_target)};
            end
        end
    end

    for (genvar gi = 0; gi < c_ENTRIES; gi++) begin : g_ctr
        logic w_sel;
        assign w_sel = w_accept && (w_up_cidx == INDEX_BITS'(gi));
        sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
            .clk     (clk),
            .reset   (reset),
            .i_inc   (w_sel && !w_alloc && upd_cond && upd_taken),
            .i_dec   (w_sel && !w_alloc && upd_cond && !upd_taken),
            .i_load  (w_sel && w_alloc),
            .o_taken (w_ctr_taken[gi])
        );
    end

    if (GHR_BITS > 0) begin : g_ghr
        logic [GHR_BITS-1:0] r_ghr;
        always_ff @(posedge clk or posedge reset) begin
            if (reset || flush) begin
                r_ghr <= '0;
            end else if (upd_valid && upd_cond) begin
                r_ghr <= GHR_BITS'({r_ghr, upd_taken});
            end
        end
        assign w_ghr_ext = INDEX_BITS'(r_ghr);
    end else begin : g_no_ghr
        assign w_ghr_ext = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_upd <= '0;
            r_stat_mis <= '0;
        end else if (w_accept) begin
            if (r_stat_upd != '1) begin
                r_stat_upd <= r_stat_upd + STAT_BITS'(1);
            end
            if (upd_mispredict && (r_stat_mis != '1)) begin
                r_stat_mis <= r_stat_mis + STAT_BITS'(1);
            end
        end
    end

    assign stat_updates = r_stat_upd;
    assign stat_mispred = r_stat_mis;

endmodule

`default_nettype wire

// File: tb/tb_btb_predictor.sv
// ============================================================================
// Module : tb_btb_predictor
// Desc   : Self-checking bench: bimodal, 2-bit-stat and gshare instances vs model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] lookup_pc = '0, upd_pc = '0, upd_target = '0;
    logic        upd_valid = 1'b0, upd_cond = 1'b0, upd_taken = 1'b0;
    logic        upd_mispredict = 1'b0, flush = 1'b0;
    logic        hit_b, tk_b, hit_s, tk_s, hit_g, tk_g;
    logic [15:0] tg_b, tg_s, tg_g, su_b, sm_b, su_g, sm_g;
    logic [1:0]  su_s, sm_s;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    btb_predictor dut_b (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .pred_hit(hit_b), .pred_taken(tk_b),
        .pred_target(tg_b), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_cond(upd_cond),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .flush(flush), .stat_updates(su_b), .stat_mispred(sm_b));

    btb_predictor #(.STAT_BITS(2)) dut_s (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .pred_hit(hit_s), .pred_taken(tk_s),
        .pred_target(tg_s), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_cond(upd_cond),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .flush(flush), .stat_updates(su_s), .stat_mispred(sm_s));

    btb_predictor #(.GHR_BITS(2)) dut_g (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .pred_hit(hit_g), .pred_taken(tk_g),
        .pred_target(tg_g), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_cond(upd_cond),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .flush(flush), .stat_updates(su_g), .stat_mispred(sm_g));

    // Reference model: 16-entry table, counters as integers 0..3.
    bit m_valid [16];
    bit m_cond  [16];
    int m_tag   [16];
    int m_tgt   [16];
    int m_ctr_b [16];
    int m_ctr_g [16];
    int m_ghr, m_upd, m_mis;

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_cond[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
            m_ctr_b[i] = 1; m_ctr_g[i] = 1;
        end
        m_ghr = 0; m_upd = 0; m_mis = 0;
    endtask

    function automatic bit m_hit(input int pc);
        return m_valid[pc % 16] && (m_tag[pc % 16] == pc / 16);
    endfunction

    function automatic bit m_taken(input int pc, input bit gs);
        int ctr;
        ctr = gs ? m_ctr_g[(pc % 16) ^ m_ghr] : m_ctr_b[pc % 16];
        return m_hit(pc) && (!m_cond[pc % 16] || ctr >= 2);
    endfunction

    function automatic int m_target(input int pc, input bit gs);
        return m_taken(pc, gs) ? m_tgt[pc % 16] : (pc + 1) % 65536;
    endfunction

    task automatic m_step();
        int  pc, idx, ci;
        bit  hit, alloc;
        if (flush) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 0;
            m_ghr = 0;
            return;
        end
        if (!upd_valid) return;
        pc = int'(upd_pc); idx = pc % 16; ci = idx ^ m_ghr;
        hit = m_hit(pc);
        alloc = !hit && upd_taken;
        if (alloc) begin
            m_ctr_b[idx] = 2; m_ctr_g[ci] = 2;
            m_valid[idx] = 1; m_cond[idx] = upd_cond; m_tag[idx] = pc / 16;
            m_tgt[idx] = int'(upd_target);
        end else if (upd_cond) begin
            if (upd_taken) begin
                if (m_ctr_b[idx] < 3) m_ctr_b[idx]++;
                if (m_ctr_g[ci] < 3) m_ctr_g[ci]++;
            end else begin
                if (m_ctr_b[idx] > 0) m_ctr_b[idx]--;
                if (m_ctr_g[ci] > 0) m_ctr_g[ci]--;
            end
        end
        if (hit && upd_taken) m_tgt[idx] = int'(upd_target);
        if (upd_cond) m_ghr = ((m_ghr << 1) | int'(upd_taken)) & 3;
        m_upd++;
        if (upd_mispredict) m_mis++;
    endtask

    task automatic drive(input logic [15:0] lpc, input logic uv, input logic [15:0] upc,
                         input logic uc, input logic ut, input logic [15:0] utg,
                         input logic um, input logic fl);
        lookup_pc = lpc; upd_valid = uv; upd_pc = upc; upd_cond = uc;
        upd_taken = ut; upd_target = utg; upd_mispredict = um; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        m_reset();
        drive(16'h0, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        #2 reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) begin
            drive(16'h0010, 1, 16'h0010, 1, 1, 16'h0077, 1, 0);
            tick();
        end
        pulse_reset();
        drive(16'h0010, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        @(negedge clk);
        n_checks++; if (hit_b !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0", hit_b); end
        n_checks++; if (tk_b !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b want 0", tk_b); end
        n_checks++; if (tg_b !== 16'h0011) begin n_fail++; $display("FAIL reset_target: got %h want 0011", tg_b); end
        n_checks++; if (su_b !== 16'h0) begin n_fail++; $display("FAIL reset_stat_upd: got %0d want 0", su_b); end
        n_checks++; if (sm_b !== 16'h0) begin n_fail++; $display("FAIL reset_stat_mis: got %0d want 0", sm_b); end
        lookup_pc = 16'hFFFF;
        #1;
        n_checks++; if (tg_b !== 16'h0000) begin n_fail++; $display("FAIL wrap_target: got %h want 0000", tg_b); end
        tick();
    endtask

    task automatic test_alloc_and_saturate();
        drive(16'h0012, 1, 16'h0012, 1, 1, 16'h0030, 0, 0);
        tick();
        drive(16'h0012, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        @(negedge clk);
        n_checks++; if (hit_b !== 1'b1) begin n_fail++; $display("FAIL alloc_hit: got %b want 1", hit_b); end
        n_checks++; if (tk_b !== 1'b1) begin n_fail++; $display("FAIL alloc_taken: got %b want 1", tk_b); end
        n_checks++; if (tg_b !== 16'h0030) begin n_fail++; $display("FAIL alloc_target: got %h want 0030", tg_b); end
        tick();
        repeat (3) begin drive(16'h0012, 1, 16'h0012, 1, 1, 16'h0030, 0, 0); tick(); end
        repeat (2) begin drive(16'h0012, 1, 16'h0012, 1, 0, 16'h0030, 0, 0); tick(); end
        drive(16'h0012, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        @(negedge clk);
        n_checks++; if (hit_b !== 1'b1) begin n_fail++; $display("FAIL sat_hit: got %b want 1", hit_b); end
        n_checks++; if (tk_b !== 1'b0) begin n_fail++; $display("FAIL sat_taken: got %b want 0", tk_b); end
        n_checks++; if (tg_b !== 16'h0013) begin n_fail++; $display("FAIL sat_target: got %h want 0013", tg_b); end
        tick();
    endtask

    task automatic test_alias();
        drive(16'h0012, 1, 16'h0022, 1, 1, 16'h0050, 0, 0);
        tick();
        drive(16'h0012, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        @(negedge clk);
        n_checks++; if (hit_b !== 1'b0) begin n_fail++; $display("FAIL alias_old_hit: got %b want 0", hit_b); end
        n_checks++; if (tg_b !== 16'h0013) begin n_fail++; $display("FAIL alias_old_target: got %h want 0013", tg_b); end
        lookup_pc = 16'h0022;
        #1;
        n_checks++; if (hit_b !== 1'b1) begin n_fail++; $display("FAIL alias_new_hit: got %b want 1", hit_b); end
        n_checks++; if (tg_b !== 16'h0050) begin n_fail++; $display("FAIL alias_new_target: got %h want 0050", tg_b); end
        tick();
    endtask

    task automatic test_same_cycle();
        drive(16'h0012, 1, 16'h0012, 1, 1, 16'h0030, 0, 0);
        tick();
        drive(16'h0012, 1, 16'h0012, 1, 1, 16'h0040, 0, 0);
        @(negedge clk);
        n_checks++; if (tg_b !== 16'h0030) begin n_fail++; $display("FAIL bypass_old_target: got %h want 0030", tg_b); end
        tick();
        drive(16'h0012, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        @(negedge clk);
        n_checks++; if (tg_b !== 16'h0040) begin n_fail++; $display("FAIL bypass_new_target: got %h want 0040", tg_b); end
        tick();
    endtask

    task automatic test_flush();
        int exp_upd, exp_mis;
        exp_upd = m_upd; exp_mis = m_mis;
        drive(16'h0012, 1, 16'h0012, 1, 1, 16'h0060, 1, 1);
        tick();
        drive(16'h0012, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        @(negedge clk);
        n_checks++; if (hit_b !== 1'b0) begin n_fail++; $display("FAIL flush_hit12: got %b want 0", hit_b); end
        n_checks++; if (hit_g !== 1'b0) begin n_fail++; $display("FAIL flush_hit12_g: got %b want 0", hit_g); end
        n_checks++; if (su_b !== 16'(exp_upd)) begin n_fail++; $display("FAIL flush_stat_upd: got %0d want %0d", su_b, exp_upd); end
        n_checks++; if (sm_b !== 16'(exp_mis)) begin n_fail++; $display("FAIL flush_stat_mis: got %0d want %0d", sm_b, exp_mis); end
        lookup_pc = 16'h0022;
        #1;
        n_checks++; if (hit_b !== 1'b0) begin n_fail++; $display("FAIL flush_hit22: got %b want 0", hit_b); end
        tick();
    endtask

    task automatic test_stat_saturate();
        pulse_reset();
        repeat (5) begin
            drive(16'h0, 1, 16'($urandom_range(0, 255)), 0, 0, 16'h0, 1, 0);
            tick();
        end
        drive(16'h0, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        @(negedge clk);
        n_checks++; if (sm_s !== 2'd3) begin n_fail++; $display("FAIL stat2_mis: got %0d want 3", sm_s); end
        n_checks++; if (su_s !== 2'd3) begin n_fail++; $display("FAIL stat2_upd: got %0d want 3", su_s); end
        n_checks++; if (sm_b !== 16'd5) begin n_fail++; $display("FAIL stat16_mis: got %0d want 5", sm_b); end
        tick();
    endtask

    task automatic test_ghr();
        pulse_reset();
        drive(16'h0005, 1, 16'h0005, 1, 1, 16'h0060, 0, 0);
        tick();
        drive(16'h0005, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        @(negedge clk);
        n_checks++; if (tk_b !== 1'b1) begin n_fail++; $display("FAIL ghr_bimodal_taken: got %b want 1", tk_b); end
        n_checks++; if (tk_g !== 1'b0) begin n_fail++; $display("FAIL ghr_gshare_taken: got %b want 0", tk_g); end
        n_checks++; if (hit_g !== 1'b1) begin n_fail++; $display("FAIL ghr_gshare_hit: got %b want 1", hit_g); end
        tick();
        for (int k = 0; k < 8; k++) begin
            drive(16'h0005, 1, 16'h0005, 1, 1'(k % 2), 16'h0060, 0, 0);
            tick();
            drive(16'h0005, 0, 16'h0, 0, 0, 16'h0, 0, 0);
            @(negedge clk);
            n_checks++; if (tk_g !== m_taken(5, 1)) begin n_fail++; $display("FAIL ghr_alt_taken[%0d]: got %b want %b", k, tk_g, m_taken(5, 1)); end
            n_checks++; if (tg_g !== 16'(m_target(5, 1))) begin n_fail++; $display("FAIL ghr_alt_target[%0d]: got %h want %h", k, tg_g, 16'(m_target(5, 1))); end
            tick();
        end
    endtask

    function automatic logic [15:0] pick_pc();
        return ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 47));
    endfunction

    task automatic test_random();
        int lp;
        for (int k = 0; k < 300; k++) begin
            drive(pick_pc(), 1'($urandom_range(0, 3) != 0), pick_pc(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 40) == 0));
            if ($urandom_range(0, 3) == 0) lookup_pc = upd_pc;
            lp = int'(lookup_pc);
            @(negedge clk);
            n_checks++; if (hit_b !== m_hit(lp)) begin n_fail++; $display("FAIL rnd_hit[%0d]: got %b want %b", k, hit_b, m_hit(lp)); end
            n_checks++; if (tk_b !== m_taken(lp, 0)) begin n_fail++; $display("FAIL rnd_taken[%0d]: got %b want %b", k, tk_b, m_taken(lp, 0)); end
            n_checks++; if (tg_b !== 16'(m_target(lp, 0))) begin n_fail++; $display("FAIL rnd_target[%0d]: got %h want %h", k, tg_b, 16'(m_target(lp, 0))); end
            n_checks++; if (tk_g !== m_taken(lp, 1)) begin n_fail++; $display("FAIL rnd_g_taken[%0d]: got %b want %b", k, tk_g, m_taken(lp, 1)); end
            n_checks++; if (tg_g !== 16'(m_target(lp, 1))) begin n_fail++; $display("FAIL rnd_g_target[%0d]: got %h want %h", k, tg_g, 16'(m_target(lp, 1))); end
            n_checks++; if (su_b !== 16'(m_upd)) begin n_fail++; $display("FAIL rnd_stat_upd[%0d]: got %0d want %0d", k, su_b, m_upd); end
            n_checks++; if (sm_s !== 2'((m_mis > 3) ? 3 : m_mis)) begin n_fail++; $display("FAIL rnd_stat2_mis[%0d]: got %0d want %0d", k, sm_s, (m_mis > 3) ? 3 : m_mis); end
            tick();
        end
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_alloc_and_saturate();
        test_alias();
        test_same_cycle();
        test_flush();
        test_stat_saturate();
        test_ghr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
